// File: rtl/instr_fetch.sv
// Instruction fetch front end: walks the fetch PC over the instruction ROM and
// buffers {pc, instr} pairs in a small prefetch queue ahead of decode.
module instr_fetch #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH+1:0] o_pc,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH+1:0] i_redirect_pc,
    output logic                  o_misalign
);

    localparam int unsigned PC_W  = ADDR_WIDTH + 2;
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [PC_W-1:0]  RST_PC  = PC_W'(RESET_PC);

    logic [PC_W-1:0]       fpc;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [PC_W-1:0]       pc_q    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] instr_q [QUEUE_DEPTH];
    logic                  pop;
    logic                  push;

    always_comb begin
        pop  = (count != '0) && i_ready;
        push = !i_redirect && ((count < DEPTH_C) || pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fpc        <= RST_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_misalign <= 1'b0;
        end else if (i_redirect) begin
            // Flush discards any same-cycle handshake along with the queue.
            fpc        <= {i_redirect_pc[PC_W-1:2], 2'b00};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_misalign <= |i_redirect_pc[1:0];
        end else begin
            o_misalign <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                fpc    <= fpc + PC_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            pc_q[wr_ptr]    <= fpc;
            instr_q[wr_ptr] <= i_rom_data;
        end
    end

    always_comb begin
        o_rom_addr = fpc[PC_W-1:2];
        o_valid    = (count != '0);
        o_instr    = o_valid ? instr_q[rd_ptr] : '0;
        o_pc       = o_valid ? pc_q[rd_ptr]    : '0;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; ROM word i holds 0xA000_0000 + i.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, ready, redirect;
    logic [9:0]  redirect_pc;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data, instr;
    logic [9:0]  pc;
    logic        valid, misalign;

    logic        w_rst;
    logic [7:0]  w_rom_addr;
    logic [31:0] w_rom_data, w_instr;
    logic [9:0]  w_pc;
    logic        w_valid, w_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data   = 32'hA000_0000 + {24'h0, rom_addr};
    assign w_rom_data = 32'hA000_0000 + {24'h0, w_rom_addr};

    instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(0), .QUEUE_DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_misalign(misalign)
    );

    instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(32'h3F8), .QUEUE_DEPTH(2)) dut_wrap (
        .i_clk(clk), .i_rst(w_rst), .o_rom_addr(w_rom_addr), .i_rom_data(w_rom_data),
        .o_valid(w_valid), .i_ready(1'b1), .o_instr(w_instr), .o_pc(w_pc),
        .i_redirect(1'b0), .i_redirect_pc(10'h0), .o_misalign(w_misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
        checks++; if (pc !== 10'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h exp 0", misalign); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr got %h exp 00", rom_addr); end
    endtask

    task automatic test_stream();
        rst = 1'b1; ready = 1'b1; redirect = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %h exp 1", k, valid); end
            checks++; if (pc !== 10'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, pc, 10'(4 * k)); end
            checks++; if (instr !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", k, instr, 32'hA000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_stall();
        rst = 1'b1; ready = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checks++; if (rom_addr !== 8'h02) begin errors++; $display("FAIL stall_rom_addr got %h exp 02", rom_addr); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %h exp 1", valid); end
        checks++; if (pc !== 10'h0) begin errors++; $display("FAIL stall_head_pc got %h exp 0", pc); end
        step();
        checks++; if (rom_addr !== 8'h02) begin errors++; $display("FAIL stall_rom_addr_hold got %h exp 02", rom_addr); end
        ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            checks++; if (pc !== 10'(4 * k)) begin errors++; $display("FAIL stall_release_pc[%0d] got %h exp %h", k, pc, 10'(4 * k)); end
            checks++; if (instr !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL stall_release_instr[%0d] got %h exp %h", k, instr, 32'hA000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_redirect();
        ready = 1'b1; redirect = 1'b1; redirect_pc = 10'h040;
        step();
        redirect = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %h exp 0", valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL redir_misalign got %h exp 0", misalign); end
        checks++; if (rom_addr !== 8'h10) begin errors++; $display("FAIL redir_rom_addr got %h exp 10", rom_addr); end
        step();
        checks++; if (pc !== 10'h040) begin errors++; $display("FAIL redir_pc got %h exp 040", pc); end
        checks++; if (instr !== 32'hA000_0010) begin errors++; $display("FAIL redir_instr got %h exp a0000010", instr); end
        step();
        checks++; if (pc !== 10'h044) begin errors++; $display("FAIL redir_next_pc got %h exp 044", pc); end
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 10'h043;
        step();
        redirect = 1'b0;
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %h exp 1", misalign); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mis_valid got %h exp 0", valid); end
        step();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %h exp 0", misalign); end
        checks++; if (pc !== 10'h040) begin errors++; $display("FAIL mis_pc got %h exp 040", pc); end
        checks++; if (instr !== 32'hA000_0010) begin errors++; $display("FAIL mis_instr got %h exp a0000010", instr); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 10'h080;
        step();
        redirect_pc = 10'h020;
        step();
        redirect = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %h exp 0", valid); end
        checks++; if (rom_addr !== 8'h08) begin errors++; $display("FAIL b2b_rom_addr got %h exp 08", rom_addr); end
        step();
        checks++; if (pc !== 10'h020) begin errors++; $display("FAIL b2b_pc got %h exp 020", pc); end
        checks++; if (instr !== 32'hA000_0008) begin errors++; $display("FAIL b2b_instr got %h exp a0000008", instr); end
    endtask

    task automatic test_wrap();
        w_rst = 1'b1;
        step();
        checks++; if (w_rom_addr !== 8'hFE) begin errors++; $display("FAIL wrap_rst_addr got %h exp fe", w_rom_addr); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL wrap_rst_valid got %h exp 0", w_valid); end
        w_rst = 1'b0;
        step();
        checks++; if (w_pc !== 10'h3F8) begin errors++; $display("FAIL wrap_pc0 got %h exp 3f8", w_pc); end
        checks++; if (w_instr !== 32'hA000_00FE) begin errors++; $display("FAIL wrap_instr0 got %h exp a00000fe", w_instr); end
        checks++; if (w_rom_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr1 got %h exp ff", w_rom_addr); end
        step();
        checks++; if (w_pc !== 10'h3FC) begin errors++; $display("FAIL wrap_pc1 got %h exp 3fc", w_pc); end
        checks++; if (w_rom_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr2 got %h exp 00", w_rom_addr); end
        step();
        checks++; if (w_pc !== 10'h000) begin errors++; $display("FAIL wrap_pc2 got %h exp 000", w_pc); end
        checks++; if (w_instr !== 32'hA000_0000) begin errors++; $display("FAIL wrap_instr2 got %h exp a0000000", w_instr); end
        step();
        checks++; if (w_pc !== 10'h004) begin errors++; $display("FAIL wrap_pc3 got %h exp 004", w_pc); end
    endtask

    task automatic test_reset_vs_redirect();
        ready = 1'b1; redirect = 1'b0;
        step(); step();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 10'h043;
        step();
        rst = 1'b0; redirect = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rvr_valid got %h exp 0", valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rvr_misalign got %h exp 0", misalign); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL rvr_rom_addr got %h exp 00", rom_addr); end
        checks++; if (pc !== 10'h0) begin errors++; $display("FAIL rvr_pc_masked got %h exp 0", pc); end
        step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rvr_restart_valid got %h exp 1", valid); end
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL rvr_restart_pc got %h exp 000", pc); end
        checks++; if (instr !== 32'hA000_0000) begin errors++; $display("FAIL rvr_restart_instr got %h exp a0000000", instr); end
    endtask

    initial begin
        w_rst = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_reset_vs_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
